sclk_burst_ctrl: RTL and testbench

//   Sequences one serial-clock burst for the SPI engine. Produces exactly 2*nbits sclk edges at
//   a programmable half-period. Applies CPOL/CPHA and emits one-cycle shift/sample strobes to the

---
 rtl/sclk_burst_ctrl.sv | 147 ++++++++++++++
 tb/tb_sclk_burst_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sclk_burst_ctrl.sv
// Serial-clock burst sequencer for the SPI engine: emits 2*nbits sclk edges at a
// programmable half-period, with CPOL/CPHA handling and shift/sample strobes.
module sclk_burst_ctrl #(
    parameter int DIV_W = 17,
    parameter int CNT_W = 6
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] halfperiod,
    input  logic [CNT_W-1:0] nbits,
    input  logic             cpol,
    input  logic             cpha,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             shift_stb,
    output logic             sample_stb
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_RUN,
        S_TAIL
    } state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   hp_q;
    logic [DIV_W-1:0]   tc_q;
    logic [DIV_W-1:0]   tc_d;
    logic [CNT_W-1:0]   nbits_q;
    logic               cpol_q;
    logic               cpha_q;
    // One bit wider than nbits so 2*nbits edges never wrap
    logic [CNT_W:0]     ec_q;
    logic [CNT_W:0]     ec_d;
    logic               busy_q;
    logic               done_q;
    logic               sclk_q;
    logic               shift_q;
    logic               sample_q;

    logic               tick;
    logic               last_edge;
    logic               lead_edge;
    logic               edge_shift;
    logic               edge_sample;

    always_comb begin
        tick        = (tc_q == hp_q);
        tc_d        = tick ? '0 : tc_q + 1'b1;
        ec_d        = ec_q + 1'b1;
        last_edge   = (ec_d == {nbits_q, 1'b0});
        lead_edge   = ec_d[0];
        // The final trailing edge in CPHA=0 has no following bit to present
        edge_shift  = lead_edge ? cpha_q : (!cpha_q && !last_edge);
        edge_sample = lead_edge ? !cpha_q : cpha_q;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hp_q     <= '0;
            tc_q     <= '0;
            nbits_q  <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            ec_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sclk_q <= cpol;
                    tc_q   <= '0;
                    ec_q   <= '0;
                    if (start) begin
                        hp_q    <= halfperiod;
                        nbits_q <= nbits;
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        if (nbits != '0) begin
                            busy_q  <= 1'b1;
                            state_q <= S_LEAD;
                            shift_q <= !cpha;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_LEAD, S_RUN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        sclk_q  <= cpol_q;
                        tc_q    <= '0;
                        ec_q    <= '0;
                    end else begin
                        tc_q <= tc_d;
                        if (tick) begin
                            sclk_q   <= ~sclk_q;
                            ec_q     <= ec_d;
                            shift_q  <= edge_shift;
                            sample_q <= edge_sample;
                            state_q  <= last_edge ? S_TAIL : S_RUN;
                        end
                    end
                end
                S_TAIL: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        sclk_q  <= cpol_q;
                        tc_q    <= '0;
                        ec_q    <= '0;
                    end else begin
                        tc_q <= tc_d;
                        if (tick) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sclk       = sclk_q;
    assign shift_stb  = shift_q;
    assign sample_stb = sample_q;

endmodule

// File: tb/tb_sclk_burst_ctrl.sv
// Scoreboard bench for sclk_burst_ctrl: expected strobe events are queued per burst
// and matched against strobes observed on the DUT outputs.
module tb_sclk_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, cpol, cpha;
    logic [16:0] halfperiod;
    logic [5:0]  nbits;
    logic        busy, done, sclk, shift_stb, sample_stb;

    always #5 clk = ~clk;

    sclk_burst_ctrl #(.DIV_W(17), .CNT_W(6)) dut (
        .clkin(clk), .rst(rst), .start(start), .abort(abort),
        .halfperiod(halfperiod), .nbits(nbits), .cpol(cpol), .cpha(cpha),
        .busy(busy), .done(done), .sclk(sclk),
        .shift_stb(shift_stb), .sample_stb(sample_stb)
    );

    typedef struct packed {
        logic [15:0] cyc;
        logic        kind;   // 0 = shift, 1 = sample
        logic        lvl;
    } ev_t;

    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    int   done_q[$];
    bit   rec = 1'b0;
    int   mon_cyc, busy_cnt, edges, both_cnt;
    logic prev_sclk;

    // Reference model of one burst, cycle 0 = first busy cycle
    function automatic void build_exp(int hp, int n, bit cp, bit ch, int off);
        int h = hp + 1;
        if (n == 0) return;
        if (!ch) exp_q.push_back('{cyc: 16'(off), kind: 1'b0, lvl: cp});
        for (int k = 1; k <= 2 * n; k++) begin
            logic l = cp ^ logic'(k % 2);
            int   c = off + k * h;
            if (k % 2 == 1)
                exp_q.push_back('{cyc: 16'(c), kind: !ch, lvl: l});
            else if (ch)
                exp_q.push_back('{cyc: 16'(c), kind: 1'b1, lvl: l});
            else if (k != 2 * n)
                exp_q.push_back('{cyc: 16'(c), kind: 1'b0, lvl: l});
        end
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            if (rec) begin
                if (busy) busy_cnt++;
                if (done) done_q.push_back(mon_cyc);
                if (sclk !== prev_sclk) edges++;
                prev_sclk = sclk;
                if (shift_stb && sample_stb) both_cnt++;
                if (shift_stb)  obs_q.push_back('{cyc: 16'(mon_cyc), kind: 1'b0, lvl: sclk});
                if (sample_stb) obs_q.push_back('{cyc: 16'(mon_cyc), kind: 1'b1, lvl: sclk});
                mon_cyc++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mon_clear();
        exp_q.delete(); obs_q.delete(); done_q.delete();
        mon_cyc = 0; busy_cnt = 0; edges = 0; both_cnt = 0;
        prev_sclk = sclk;
        rec = 1'b1;
    endtask

    task automatic start_burst(int hp, int n, bit cp, bit ch);
        halfperiod = 17'(hp); nbits = 6'(n); cpol = cp; cpha = ch; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mon_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1; cpol = 1'b1; cpha = 1'b0;
        halfperiod = '0; nbits = 6'd3;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", sclk); end
        checks++; if ({shift_stb, sample_stb} !== 2'b00) begin
            failures++; $display("FAIL rst_strobes got=%b%b exp=00", shift_stb, sample_stb);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0; cpol = 1'b0;
        step(2);
    endtask

    task automatic test_basic();
        ev_t e, o;
        start_burst(1, 8, 1'b0, 1'b0);
        build_exp(1, 8, 1'b0, 1'b0, 0);
        step(40);
        checks++; if (busy_cnt != 34) begin failures++; $display("FAIL basic_busy_len got=%0d exp=34", busy_cnt); end
        checks++; if (edges != 16) begin failures++; $display("FAIL basic_edges got=%0d exp=16", edges); end
        checks++; if (done_q.size() != 1 || done_q[0] != 34) begin
            failures++; $display("FAIL basic_done got_n=%0d exp_n=1 exp_cyc=34", done_q.size());
        end
        checks++; if (both_cnt != 0) begin failures++; $display("FAIL basic_overlap got=%0d exp=0", both_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL basic_sb_missing got=none exp=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL basic_sb got=%h exp=%h", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL basic_sb_extra got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_cpol_cpha();
        ev_t e, o;
        rec = 1'b0;
        cpol = 1'b1;
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL idle_lag got=%b exp=0", sclk); end
        step(1);
        checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL idle_track got=%b exp=1", sclk); end
        start_burst(0, 3, 1'b1, 1'b1);
        build_exp(0, 3, 1'b1, 1'b1, 0);
        step(12);
        checks++; if (busy_cnt != 7) begin failures++; $display("FAIL cp_busy_len got=%0d exp=7", busy_cnt); end
        checks++; if (edges != 6) begin failures++; $display("FAIL cp_edges got=%0d exp=6", edges); end
        checks++; if (done_q.size() != 1 || done_q[0] != 7) begin
            failures++; $display("FAIL cp_done got_n=%0d exp_n=1 exp_cyc=7", done_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL cp_sb_missing got=none exp=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL cp_sb got=%h exp=%h", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL cp_sb_extra got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_zero_bits();
        start_burst(5, 0, 1'b1, 1'b0);
        step(8);
        checks++; if (done_q.size() != 1 || done_q[0] != 0) begin
            failures++; $display("FAIL zero_done got_n=%0d exp_n=1 exp_cyc=0", done_q.size());
        end
        checks++; if (busy_cnt != 0) begin failures++; $display("FAIL zero_busy got=%0d exp=0", busy_cnt); end
        checks++; if (edges != 0) begin failures++; $display("FAIL zero_edges got=%0d exp=0", edges); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL zero_strobes got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_abort();
        ev_t e, o;
        rec = 1'b0;
        cpol = 1'b0;
        abort = 1'b1;
        step(2);
        abort = 1'b0;
        start_burst(2, 4, 1'b0, 1'b0);
        build_exp(2, 4, 1'b0, 1'b0, 0);
        while (exp_q.size() > 0 && exp_q[$].cyc > 16'd15) void'(exp_q.pop_back());
        step(15);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL abort_sclk got=%b exp=0", sclk); end
        checks++; if ({shift_stb, sample_stb} !== 2'b00) begin
            failures++; $display("FAIL abort_strobes got=%b%b exp=00", shift_stb, sample_stb);
        end
        step(12);
        checks++; if (done_q.size() != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_q.size()); end
        checks++; if (busy_cnt != 16) begin failures++; $display("FAIL abort_busy_len got=%0d exp=16", busy_cnt); end
        checks++; if (edges != 6) begin failures++; $display("FAIL abort_edges got=%0d exp=6", edges); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL abort_sb_missing got=none exp=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL abort_sb got=%h exp=%h", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL abort_sb_extra got=%0d exp=0", obs_q.size()); end
        start_burst(0, 2, 1'b1, 1'b0);
        build_exp(0, 2, 1'b1, 1'b0, 0);
        step(8);
        checks++; if (done_q.size() != 1 || done_q[0] != 5) begin
            failures++; $display("FAIL restart_done got_n=%0d exp_n=1 exp_cyc=5", done_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL restart_sb_missing got=none exp=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL restart_sb got=%h exp=%h", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL restart_sb_extra got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        rec = 1'b0;
        halfperiod = '0; nbits = 6'd2; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        mon_clear();
        build_exp(0, 2, 1'b0, 1'b0, 0);
        build_exp(0, 2, 1'b0, 1'b0, 6);
        step(1);
        halfperiod = 17'd5; nbits = 6'd7; cpha = 1'b1;
        step(3);
        halfperiod = '0; nbits = 6'd2; cpha = 1'b0;
        step(2);
        start = 1'b0; halfperiod = 17'd3; nbits = 6'd5; cpol = 1'b1;
        step(10);
        cpol = 1'b0;
        checks++; if (busy_cnt != 10) begin failures++; $display("FAIL b2b_busy_len got=%0d exp=10", busy_cnt); end
        checks++; if (done_q.size() != 2) begin
            failures++; $display("FAIL b2b_done_n got=%0d exp=2", done_q.size());
        end else begin
            checks++; if (done_q[0] != 5 || done_q[1] != 11) begin
                failures++; $display("FAIL b2b_done_cyc got=%0d,%0d exp=5,11", done_q[0], done_q[1]);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL b2b_sb_missing got=none exp=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL b2b_sb got=%h exp=%h", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL b2b_sb_extra got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_rst_mid_run();
        ev_t e, o;
        step(2);
        start_burst(1, 8, 1'b1, 1'b1);
        step(10);
        rec = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL midrst_sclk got=%b exp=0", sclk); end
        checks++; if ({done, shift_stb, sample_stb} !== 3'b000) begin
            failures++; $display("FAIL midrst_pulses got=%b%b%b exp=000", done, shift_stb, sample_stb);
        end
        step(2);
        start_burst(1, 5, 1'b1, 1'b1);
        build_exp(1, 5, 1'b1, 1'b1, 0);
        step(26);
        checks++; if (busy_cnt != 22) begin failures++; $display("FAIL postrst_busy_len got=%0d exp=22", busy_cnt); end
        checks++; if (done_q.size() != 1 || done_q[0] != 22) begin
            failures++; $display("FAIL postrst_done got_n=%0d exp_n=1 exp_cyc=22", done_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL postrst_sb_missing got=none exp=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL postrst_sb got=%h exp=%h", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL postrst_sb_extra got=%0d exp=0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cpol_cpha();
        test_zero_bits();
        test_abort();
        test_back_to_back();
        test_rst_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
